// File: rtl/gpio_pkg.sv
// Shared types and defaults for the button-to-LED scheduler: per-channel LED state encoding,
// default timing constants, and the next-state / LED-drive decode used by every channel.
package gpio_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int BLINK_DIV_DEF       = 12500000;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_BLINK = 2'd2
    } led_state_t;

    // The unused encoding 2'd3 falls into default and recovers to OFF.
    function automatic led_state_t next_state(input led_state_t cur, input logic press);
        led_state_t nxt;
        nxt = ST_OFF;
        case (cur)
            ST_OFF:   nxt = press ? ST_ON    : ST_OFF;
            ST_ON:    nxt = press ? ST_BLINK : ST_ON;
            ST_BLINK: nxt = press ? ST_OFF   : ST_BLINK;
            default:  nxt = ST_OFF;
        endcase
        return nxt;
    endfunction

    function automatic logic led_drive(input led_state_t cur, input logic phase);
        logic val;
        val = 1'b0;
        case (cur)
            ST_ON:    val = 1'b1;
            ST_BLINK: val = phase;
            default:  val = 1'b0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-button 2-flop synchronizer, counter debounce and rising-edge press pulse.
// Latency: press fires DEBOUNCE_CYCLES+2 edges after the first edge sampling a new level; no backpressure.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b00;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Counter reaches DEBOUNCE_CYCLES on this edge: accept the level.
                stable <= sync[1];
                cnt    <= '0;
                press  <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_led_scheduler.sv
// Three debounced buttons each cycle their LED through OFF -> ON -> BLINK (shared free-running phase).
// Latency: DEBOUNCE_CYCLES+4 edges from first sampled press level to LED; no backpressure.
module gpio_led_scheduler
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int BLINK_DIV       = BLINK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic input_b1,
    input  logic input_b2,
    input  logic input_b3,
    output logic output_led1,
    output logic output_led2,
    output logic output_led3,
    output logic blink_phase
);

    localparam int               DIV_W    = $clog2(BLINK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

    logic [2:0]       btn;
    logic [2:0]       press;
    logic [2:0]       led;
    logic [DIV_W-1:0] div_cnt;

    assign btn = {input_b3, input_b2, input_b1};

    // The divider is never restarted by a channel entering BLINK; all LEDs share one phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        led_state_t state;
        logic       led_q;

        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn[i]),
            .press (press[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_OFF;
                led_q <= 1'b0;
            end else begin
                state <= next_state(state, press[i]);
                led_q <= led_drive(state, blink_phase);
            end
        end

        assign led[i] = led_q;
    end

    assign output_led1 = led[0];
    assign output_led2 = led[1];
    assign output_led3 = led[2];

endmodule

// File: tb/tb_gpio_led_scheduler.sv
// Directed bench for gpio_led_scheduler with DEBOUNCE_CYCLES=4, BLINK_DIV=8.
module tb_gpio_led_scheduler;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic clk;
    logic rst_n;
    logic input_b1, input_b2, input_b3;
    logic output_led1, output_led2, output_led3;
    logic blink_phase;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    gpio_led_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_DIV      (DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_b1    (input_b1),
        .input_b2    (input_b2),
        .input_b3    (input_b3),
        .output_led1 (output_led1),
        .output_led2 (output_led2),
        .output_led3 (output_led3),
        .blink_phase (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; phase after edge k is (k/DIV) mod 2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic exp_phase(input int k);
        return ((k / DIV) % 2) == 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [2:0] v);
        input_b1 = v[0];
        input_b2 = v[1];
        input_b3 = v[2];
    endtask

    function automatic logic [2:0] leds();
        return {output_led3, output_led2, output_led1};
    endfunction

    // Clean press: held long enough to debounce, then released long enough to settle.
    task automatic press_btn(input logic [2:0] v);
        set_btn(v);
        tick(10);
        set_btn(3'b000);
        tick(10);
    endtask

    initial begin
        rst_n = 1'b0;
        set_btn(3'b000);
        tick(3);
        check_eq("reset_leds", 32'(leds()), 32'd0);
        check_eq("reset_phase", 32'(blink_phase), 32'd0);
        rst_n = 1'b1;

        // Idle: LEDs stay dark, phase toggles every DIV edges.
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check_eq("idle_leds", 32'(leds()), 32'd0);
            check_eq("idle_phase", 32'(blink_phase), 32'(exp_phase(cyc)));
        end

        // b1 held 20 cycles: LED rises exactly DEB+4 edges after first sample.
        set_btn(3'b001);
        tick(DEB + 3);
        check_eq("b1_before_latency", 32'(leds()), 32'd0);
        tick(1);
        check_eq("b1_at_latency", 32'(leds()), 32'b001);
        tick(20 - (DEB + 4));
        set_btn(3'b000);
        tick(10);
        check_eq("b1_after_release", 32'(leds()), 32'b001);

        // b2 bounce shorter than the debounce window is ignored.
        for (int r = 0; r < 5; r++) begin
            input_b2 = 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                check_eq("b2_glitch_hi", 32'(output_led2), 32'd0);
            end
            input_b2 = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                check_eq("b2_glitch_lo", 32'(output_led2), 32'd0);
            end
        end
        tick(10);
        check_eq("b2_glitch_settled", 32'(leds()), 32'b001);
        // A clean press afterwards goes to ON, so the glitches left the state at OFF.
        press_btn(3'b010);
        check_eq("b2_clean_on", 32'(leds()), 32'b011);

        // b3: OFF -> ON -> BLINK (tracks phase one edge late) -> OFF.
        press_btn(3'b100);
        check_eq("b3_on", 32'(output_led3), 32'd1);
        press_btn(3'b100);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("b3_blink", 32'(output_led3), 32'(exp_phase(cyc - 1)));
        end
        press_btn(3'b100);
        check_eq("b3_off", 32'(output_led3), 32'd0);

        // b1 (ON -> BLINK) and b3 (OFF -> ON) pressed together update on the same edge.
        set_btn(3'b101);
        tick(DEB + 3);
        check_eq("dual_before_l1", 32'(output_led1), 32'd1);
        check_eq("dual_before_l3", 32'(output_led3), 32'd0);
        tick(1);
        check_eq("dual_at_l3", 32'(output_led3), 32'd1);
        check_eq("dual_at_l1", 32'(output_led1), 32'(exp_phase(cyc - 1)));
        tick(2);
        set_btn(3'b000);
        tick(10);
        check_eq("dual_l1_blink", 32'(output_led1), 32'(exp_phase(cyc - 1)));

        // Reset while ch1 blinks and b2 is mid-debounce.
        input_b2 = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_leds", 32'(leds()), 32'd0);
        check_eq("midrst_phase", 32'(blink_phase), 32'd0);
        input_b2 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            check_eq("postrst_leds", 32'(leds()), 32'd0);
            check_eq("postrst_phase", 32'(blink_phase), 32'(exp_phase(cyc)));
        end

        // A button held across reset release counts as a press once debounced.
        rst_n = 1'b0;
        input_b1 = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(DEB + 3);
        check_eq("held_rst_before", 32'(leds()), 32'd0);
        tick(1);
        check_eq("held_rst_on", 32'(leds()), 32'b001);
        input_b1 = 1'b0;
        tick(10);
        check_eq("held_rst_release", 32'(leds()), 32'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
